smart_home: RTL and testbench

Home-automation controller that combines three independent registered functions on one clock: a thermostat (heating/cooling with hysteresis), an RGB mood-light colour cycler driven by a push button, and a two-blind controller driven by a light-intensity sensor with a manual override. It sits between the sensor/button inputs and the actuator drivers. All outputs are registered.

---
 rtl/smart_home_pkg.sv | 24 ++
 rtl/smart_home_ac_controller.sv | 50 +++++
 rtl/smart_home.sv | 59 +++++
 tb/tb_smart_home.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/smart_home_pkg.sv
// rtl/smart_home_pkg.sv - shared constants and types for the smart_home controller
package smart_home_pkg;

  typedef enum logic [1:0] {
    TS_IDLE = 2'd0,
    TS_HEAT = 2'd1,
    TS_COOL = 2'd2
  } therm_state_e;

  localparam logic [4:0] DEF_T_HEAT_ON = 5'd18;
  localparam logic [4:0] DEF_T_COOL_ON = 5'd22;
  localparam logic [4:0] DEF_T_TARGET  = 5'd20;

  localparam logic [2:0] COLOUR_MIN = 3'd1;
  localparam logic [2:0] COLOUR_MAX = 3'd6;

  localparam logic [3:0] INTENSITY_DARK_MAX = 4'd3;
  localparam logic [3:0] INTENSITY_MID_MAX  = 4'd6;

  localparam logic [1:0] BLINDS_OPEN   = 2'b00;
  localparam logic [1:0] BLINDS_B_ONLY = 2'b01;
  localparam logic [1:0] BLINDS_CLOSED = 2'b11;

endpackage

// File: rtl/smart_home_ac_controller.sv
// rtl/smart_home_ac_controller.sv - thermostat FSM with hysteresis
module ac_controller
  import smart_home_pkg::*;
#(
  parameter logic [4:0] T_HEAT_ON = DEF_T_HEAT_ON,
  parameter logic [4:0] T_COOL_ON = DEF_T_COOL_ON,
  parameter logic [4:0] T_TARGET  = DEF_T_TARGET
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] temperature,
  output logic       heating,
  output logic       cooling
);

  localparam logic [1:0] IDLE = TS_IDLE;
  localparam logic [1:0] HEAT = TS_HEAT;
  localparam logic [1:0] COOL = TS_COOL;

  logic [1:0] state;
  logic [1:0] next_state;

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE: begin
        if (temperature <= T_HEAT_ON)      next_state = HEAT;
        else if (temperature >= T_COOL_ON) next_state = COOL;
        else                               next_state = IDLE;
      end
      HEAT:    next_state = (temperature >= T_TARGET) ? IDLE : HEAT;
      COOL:    next_state = (temperature <= T_TARGET) ? IDLE : COOL;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are flopped from next_state so they stay glitch-free Moore outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      heating <= 1'b0;
      cooling <= 1'b0;
    end else begin
      state   <= next_state;
      heating <= (next_state == HEAT);
      cooling <= (next_state == COOL);
    end
  end

endmodule

// File: rtl/smart_home.sv
// rtl/smart_home.sv - thermostat, colour cycler and blind controller on one clock
module smart_home
  import smart_home_pkg::*;
#(
  parameter logic [4:0] T_HEAT_ON = DEF_T_HEAT_ON,
  parameter logic [4:0] T_COOL_ON = DEF_T_COOL_ON,
  parameter logic [4:0] T_TARGET  = DEF_T_TARGET
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] temperature,
  input  logic       button,
  input  logic [3:0] intensity,
  input  logic       button_blinders,
  output logic       heating,
  output logic       cooling,
  output logic [2:0] colour,
  output logic [1:0] out
);

  ac_controller #(
    .T_HEAT_ON (T_HEAT_ON),
    .T_COOL_ON (T_COOL_ON),
    .T_TARGET  (T_TARGET)
  ) u_ac (
    .clk         (clk),
    .rst         (rst),
    .temperature (temperature),
    .heating     (heating),
    .cooling     (cooling)
  );

  // 0 and 7 are not running colours; recover to the first colour unconditionally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      colour <= 3'd0;
    end else if (colour < COLOUR_MIN || colour > COLOUR_MAX) begin
      colour <= COLOUR_MIN;
    end else if (button) begin
      colour <= (colour == COLOUR_MAX) ? COLOUR_MIN : colour + 3'd1;
    end
  end

  // Out-of-range intensity falls through to the bright band.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= BLINDS_OPEN;
    end else if (button_blinders) begin
      out <= BLINDS_CLOSED;
    end else if (intensity <= INTENSITY_DARK_MAX) begin
      out <= BLINDS_OPEN;
    end else if (intensity <= INTENSITY_MID_MAX) begin
      out <= BLINDS_B_ONLY;
    end else begin
      out <= BLINDS_CLOSED;
    end
  end

endmodule

// File: tb/tb_smart_home.sv
// tb/tb_smart_home.sv - scoreboard bench for smart_home
module tb_smart_home;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] temperature = 5'd0;
  logic       button = 1'b0;
  logic [3:0] intensity = 4'd0;
  logic       button_blinders = 1'b0;
  logic       heating;
  logic       cooling;
  logic [2:0] colour;
  logic [1:0] out;

  smart_home dut (
    .clk             (clk),
    .rst             (rst),
    .temperature     (temperature),
    .button          (button),
    .intensity       (intensity),
    .button_blinders (button_blinders),
    .heating         (heating),
    .cooling         (cooling),
    .colour          (colour),
    .out             (out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       heat;
    logic       cool;
    logic [2:0] col;
    logic [1:0] blinds;
  } exp_t;

  exp_t sb[$];

  int total_cnt = 0;
  int pass_cnt  = 0;

  // Reference model: 0 idle, 1 heat, 2 cool
  int         m_state = 0;
  logic [2:0] m_col   = 3'd0;
  logic [1:0] m_out   = 2'b00;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_state = 0;
    m_col   = 3'd0;
    m_out   = 2'b00;
  endtask

  task automatic model_advance();
    int t;
    t = int'(temperature);
    case (m_state)
      0:       m_state = (t <= 18) ? 1 : ((t >= 22) ? 2 : 0);
      1:       m_state = (t >= 20) ? 0 : 1;
      default: m_state = (t <= 20) ? 0 : 2;
    endcase
    if (m_col == 3'd0 || m_col == 3'd7) m_col = 3'd1;
    else if (button)                    m_col = (m_col == 3'd6) ? 3'd1 : m_col + 3'd1;
    if (button_blinders)        m_out = 2'b11;
    else if (intensity <= 4'd3) m_out = 2'b00;
    else if (intensity <= 4'd6) m_out = 2'b01;
    else                        m_out = 2'b11;
  endtask

  task automatic step(input string tag);
    exp_t e;
    model_advance();
    e.heat   = (m_state == 1);
    e.cool   = (m_state == 2);
    e.col    = m_col;
    e.blinds = m_out;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".heating"}, {7'd0, heating}, {7'd0, e.heat});
    check({tag, ".cooling"}, {7'd0, cooling}, {7'd0, e.cool});
    check({tag, ".colour"},  {5'd0, colour},  {5'd0, e.col});
    check({tag, ".out"},     {6'd0, out},     {6'd0, e.blinds});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".heating"}, {7'd0, heating}, 8'd0);
    check({tag, ".cooling"}, {7'd0, cooling}, 8'd0);
    check({tag, ".colour"},  {5'd0, colour},  8'd0);
    check({tag, ".out"},     {6'd0, out},     8'd0);
  endtask

  logic [2:0] col_seq [8];
  logic [1:0] blind_exp [7];
  logic [3:0] blind_int [7];

  initial begin
    col_seq   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1, 3'd2};
    blind_int = '{4'd0, 4'd3, 4'd4, 4'd6, 4'd7, 4'd9, 4'd12};
    blind_exp = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11};

    // Reset asserted away from a clock edge, with busy inputs
    button = 1'b1; temperature = 5'd15; button_blinders = 1'b1;
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_immediate");
    model_reset();
    @(posedge clk); #1;
    check_reset_outputs("rst_held");
    rst = 1'b0;
    button_blinders = 1'b0;

    // Colour cycle: first edge recovers to 1, then advances while held
    for (int i = 0; i < 8; i++) begin
      step("colour_run");
      check("colour_seq", {5'd0, colour}, {5'd0, col_seq[i]});
    end
    button = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("colour_hold");
      check("colour_hold_val", {5'd0, colour}, 8'd2);
    end

    // Thermostat ramp up and down
    for (int t = 15; t <= 31; t++) begin
      temperature = 5'(t);
      step("therm_up");
    end
    check("therm_top_cool", {7'd0, cooling}, 8'd1);
    for (int t = 31; t >= 15; t--) begin
      temperature = 5'(t);
      step("therm_down");
    end
    check("therm_bottom_heat", {7'd0, heating}, 8'd1);

    // Hysteresis holds
    temperature = 5'd20; step("hyst_to_idle");
    temperature = 5'd19; step("hyst_idle19");
    check("hyst_idle19_heat", {7'd0, heating}, 8'd0);
    temperature = 5'd18; step("hyst_heat18");
    temperature = 5'd19;
    for (int i = 0; i < 3; i++) step("hyst_heat19");
    check("hyst_heat19_on", {7'd0, heating}, 8'd1);
    temperature = 5'd31;
    step("leap_heat_to_idle");
    check("leap_not_cool_yet", {7'd0, cooling}, 8'd0);
    step("leap_idle_to_cool");
    check("leap_cool", {7'd0, cooling}, 8'd1);
    temperature = 5'd21;
    for (int i = 0; i < 3; i++) step("hyst_cool21");
    check("hyst_cool21_on", {7'd0, cooling}, 8'd1);

    // Blinds bands and override
    for (int i = 0; i < 7; i++) begin
      intensity = blind_int[i];
      step("blinds_band");
      check("blinds_table", {6'd0, out}, {6'd0, blind_exp[i]});
    end
    intensity = 4'd0; button_blinders = 1'b1;
    step("blinds_override");
    check("blinds_override_val", {6'd0, out}, 8'h03);
    button_blinders = 1'b0;

    // Mid-run reset with HEAT active and colour 4
    temperature = 5'd15;
    step("pre_rst_idle");
    step("pre_rst_heat");
    button = 1'b1;
    for (int i = 0; i < 6 && m_col != 3'd4; i++) step("pre_rst_colour");
    button = 1'b0;
    check("pre_rst_colour4", {5'd0, colour}, 8'd4);
    check("pre_rst_heating", {7'd0, heating}, 8'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrun_rst");
    model_reset();
    #3 rst = 1'b0;
    step("post_rst");
    check("post_rst_colour1", {5'd0, colour}, 8'd1);

    check("sb_drained", 8'(sb.size()), 8'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
